// File: rtl/rf_operand_fetch_if.sv
// Signal bundle between decode, the register file read/write ports and execute for rf_operand_fetch.
// The slave modport is the operand-fetch view; master is the surrounding pipeline's view.
interface rf_operand_fetch_if #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [ADDR_W-1:0]    i_rs1;
    logic [ADDR_W-1:0]    i_rs2;
    logic [ADDR_W-1:0]    i_rd;
    logic                 i_rd_we;
    logic [PAYLOAD_W-1:0] i_payload;

    logic [ADDR_W-1:0]    o_rd_addr_1port;
    logic [ADDR_W-1:0]    o_rd_addr_2port;
    logic [DATA_W-1:0]    i_rd_data_1port;
    logic [DATA_W-1:0]    i_rd_data_2port;

    logic [ADDR_W-1:0]    i_wr_addr;
    logic [DATA_W-1:0]    i_wr_data;
    logic                 i_wr_en;

    logic                 o_valid;
    logic                 i_ready;
    logic [DATA_W-1:0]    o_rs1_data;
    logic [DATA_W-1:0]    o_rs2_data;
    logic [ADDR_W-1:0]    o_rd;
    logic                 o_rd_we;
    logic [PAYLOAD_W-1:0] o_payload;

    modport slave (
        input  i_valid, i_rs1, i_rs2, i_rd, i_rd_we, i_payload,
        input  i_rd_data_1port, i_rd_data_2port,
        input  i_wr_addr, i_wr_data, i_wr_en,
        input  i_ready,
        output o_ready, o_rd_addr_1port, o_rd_addr_2port,
        output o_valid, o_rs1_data, o_rs2_data, o_rd, o_rd_we, o_payload
    );

    modport master (
        output i_valid, i_rs1, i_rs2, i_rd, i_rd_we, i_payload,
        output i_rd_data_1port, i_rd_data_2port,
        output i_wr_addr, i_wr_data, i_wr_en,
        output i_ready,
        input  o_ready, o_rd_addr_1port, o_rd_addr_2port,
        input  o_valid, o_rs1_data, o_rs2_data, o_rd, o_rd_we, o_payload
    );
endinterface

// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: reads both RF ports, forwards same-cycle writeback, and tracks a
// per-register busy scoreboard that stalls RAW/WAW hazards. One-cycle registered output.
module rf_operand_fetch #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    rf_operand_fetch_if.slave  bus
);
    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [NREGS-1:0]     busy_q, busy_d;
    logic [NREGS-1:0]     wb_c;
    logic                 stall_c, ready_c, accept_c;

    logic                 valid_q;
    logic [DATA_W-1:0]    rs1_data_q, rs2_data_q;
    logic [ADDR_W-1:0]    rd_q;
    logic                 rd_we_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [DATA_W-1:0]    rs1_fwd_c, rs2_fwd_c;

    function automatic logic haz(input logic [ADDR_W-1:0] r,
                                 input logic [NREGS-1:0]  busy,
                                 input logic [NREGS-1:0]  wb);
        return (r != '0) && busy[r] && !wb[r];
    endfunction

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] rs,
                                              input logic [DATA_W-1:0] port_data,
                                              input logic [NREGS-1:0]  wb,
                                              input logic [DATA_W-1:0] wr_data);
        logic [DATA_W-1:0] res;
        res = port_data;
        if (rs == '0)     res = '0;
        else if (wb[rs])  res = wr_data;
        return res;
    endfunction

    // Same-cycle writeback decode; register 0 never counts as written.
    always_comb begin
        wb_c = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            wb_c[r] = bus.i_wr_en && (bus.i_wr_addr == ADDR_W'(r));
        end
    end

    always_comb begin
        stall_c  = haz(bus.i_rs1, busy_q, wb_c) ||
                   haz(bus.i_rs2, busy_q, wb_c) ||
                   (bus.i_rd_we && haz(bus.i_rd, busy_q, wb_c));
        ready_c  = !stall_c && (!valid_q || bus.i_ready);
        accept_c = bus.i_valid && ready_c;
        rs1_fwd_c = fwd(bus.i_rs1, bus.i_rd_data_1port, wb_c, bus.i_wr_data);
        rs2_fwd_c = fwd(bus.i_rs2, bus.i_rd_data_2port, wb_c, bus.i_wr_data);
    end

    // Writeback clears first so a same-index set in the same cycle wins.
    always_comb begin
        busy_d = busy_q & ~wb_c;
        if (accept_c && bus.i_rd_we && (bus.i_rd != '0)) begin
            busy_d[bus.i_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            payload_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept_c) begin
                valid_q    <= 1'b1;
                rs1_data_q <= rs1_fwd_c;
                rs2_data_q <= rs2_fwd_c;
                rd_q       <= bus.i_rd;
                rd_we_q    <= bus.i_rd_we;
                payload_q  <= bus.i_payload;
            end else if (valid_q && bus.i_ready) begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign bus.o_ready         = ready_c;
    assign bus.o_rd_addr_1port = bus.i_rs1;
    assign bus.o_rd_addr_2port = bus.i_rs2;
    assign bus.o_valid         = valid_q;
    assign bus.o_rs1_data      = rs1_data_q;
    assign bus.o_rs2_data      = rs2_data_q;
    assign bus.o_rd            = rd_q;
    assign bus.o_rd_we         = rd_we_q;
    assign bus.o_payload       = payload_q;
endmodule
